addand_seq: RTL and testbench

ADDAND_SEQ -- requirements
Module: addand_seq

---
 rtl/addand_seq.sv | 156 +++++++++++++++
 tb/tb_addand_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/addand_seq.sv
// addand_seq: sequential ADD/AND/rotate unit with a link (carry) bit.
// One operation is accepted from IDLE, executed over one or two RUN cycles,
// and announced with a single-cycle DONE pulse in FIN.
// Optional feature: define ADDAND_SEQ_BSW_EN to make OP=6 swap the halves
// of A; without it OP=6 behaves exactly like PASS.
module addand_seq #(
   parameter int WIDTH = 12
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic [2:0]       OP,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CI,
   output logic [WIDTH-1:0] RESULT,
   output logic             LINK,
   output logic             BUSY,
   output logic             DONE
);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_RAL  = 3'd2;
   localparam logic [2:0] OP_RAR  = 3'd3;
   localparam logic [2:0] OP_RTL  = 3'd4;
   localparam logic [2:0] OP_RTR  = 3'd5;
`ifdef ADDAND_SEQ_BSW_EN
   localparam logic [2:0] OP_BSW  = 3'd6;
`endif

   // Operand width must be even so the half swap splits cleanly.
   if (WIDTH < 4 || WIDTH > 32 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("addand_seq: WIDTH must be even and in 4..32");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t             state;
   logic [1:0]         cnt_q;

   // Captured operation; a_q/l_q double as the working word between the
   // two single-position steps of RTL/RTR.
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               l_q;

   // Result of the step performed in the current RUN cycle, {link, data}.
   logic [WIDTH:0]     step_w;

   // Rotate the (WIDTH+1)-bit {link, data} word one place left.
   function automatic logic [WIDTH:0] rot_left(input logic [WIDTH:0] w);
      return {w[WIDTH-1:0], w[WIDTH]};
   endfunction

   // Rotate the (WIDTH+1)-bit {link, data} word one place right.
   function automatic logic [WIDTH:0] rot_right(input logic [WIDTH:0] w);
      return {w[0], w[WIDTH:1]};
   endfunction

   // WIDTH+1 bit sum; the top bit becomes the link.
   function automatic logic [WIDTH:0] add_word(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             c);
      logic [WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
      return sum;
   endfunction

`ifdef ADDAND_SEQ_BSW_EN
   // Exchange the upper and lower WIDTH/2-bit halves.
   function automatic logic [WIDTH-1:0] swap_halves(input logic [WIDTH-1:0] a);
      return {a[WIDTH/2-1:0], a[WIDTH-1:WIDTH/2]};
   endfunction
`endif

   // Number of RUN cycles an opcode needs.
   function automatic logic [1:0] steps_for(input logic [2:0] op);
      logic [1:0] n;
      n = ((op == OP_RTL) || (op == OP_RTR)) ? 2'd2 : 2'd1;
      return n;
   endfunction

   // One execution step on the captured/working operands.
   always_comb begin
      step_w = {l_q, a_q};
      unique case (op_q)
         OP_ADD:  step_w = add_word(a_q, b_q, l_q);
         OP_AND:  step_w = {l_q, a_q & b_q};
         OP_RAL,
         OP_RTL:  step_w = rot_left({l_q, a_q});
         OP_RAR,
         OP_RTR:  step_w = rot_right({l_q, a_q});
`ifdef ADDAND_SEQ_BSW_EN
         OP_BSW:  step_w = {l_q, swap_halves(a_q)};
`endif
         default: step_w = {l_q, a_q};
      endcase
   end

   // Control FSM, step counter and the registered RESULT/LINK outputs.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state  <= S_IDLE;
         cnt_q  <= 2'd0;
         RESULT <= '0;
         LINK   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (START) begin
                  cnt_q <= steps_for(OP);
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               cnt_q <= cnt_q - 2'd1;
               if (cnt_q == 2'd1) begin
                  RESULT <= step_w[WIDTH-1:0];
                  LINK   <= step_w[WIDTH];
                  state  <= S_FIN;
               end
            end
            S_FIN: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               cnt_q <= 2'd0;
            end
         endcase
      end
   end

   // Operand capture in IDLE and working-word update between RUN steps.
   always_ff @(posedge CLK) begin
      if (state == S_IDLE && START) begin
         op_q <= OP;
         a_q  <= A;
         b_q  <= B;
         l_q  <= CI;
      end else if (state == S_RUN) begin
         a_q  <= step_w[WIDTH-1:0];
         l_q  <= step_w[WIDTH];
      end
   end

   assign BUSY = (state != S_IDLE);
   assign DONE = (state == S_FIN);

endmodule

// File: tb/tb_addand_seq.sv
// Directed bench for addand_seq at WIDTH=12 with octal vectors.
module tb_addand_seq;

   localparam int W = 12;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          START;
   logic [2:0]    OP;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          CI;
   logic [W-1:0]  RESULT;
   logic          LINK;
   logic          BUSY;
   logic          DONE;

   int n_chk  = 0;
   int n_fail = 0;

   addand_seq #(.WIDTH(W)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .START   (START),
      .OP      (OP),
      .A       (A),
      .B       (B),
      .CI      (CI),
      .RESULT  (RESULT),
      .LINK    (LINK),
      .BUSY    (BUSY),
      .DONE    (DONE)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
      end
   endtask

   // Issue one operation, scramble inputs after capture, and check the
   // fixed timing: BUSY after edge k, DONE only after edge k+steps.
   task automatic run_op(input string tag, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input int steps,
                         input logic [W-1:0] exp_r, input logic exp_l);
      OP = op; A = a; B = b; CI = ci; START = 1'b1;
      tick();
      START = 1'b0;
      OP = ~op; A = ~a; B = ~b; CI = ~ci;
      chk({tag, "_busy_k"}, BUSY, 1);
      chk({tag, "_done_k"}, DONE, 0);
      for (int i = 1; i <= steps; i++) begin
         tick();
         if (i < steps) begin
            chk({tag, "_done_early"}, DONE, 0);
            chk({tag, "_busy_mid"}, BUSY, 1);
         end
      end
      chk({tag, "_done"}, DONE, 1);
      chk({tag, "_busy_fin"}, BUSY, 1);
      chk({tag, "_result"}, RESULT, exp_r);
      chk({tag, "_link"}, LINK, exp_l);
      tick();
      chk({tag, "_done_end"}, DONE, 0);
      chk({tag, "_busy_end"}, BUSY, 0);
      chk({tag, "_result_hold"}, RESULT, exp_r);
      chk({tag, "_link_hold"}, LINK, exp_l);
   endtask

   initial begin
      logic [W-1:0] bsw_exp;

      RESET_N = 1'b0; START = 1'b0; OP = 3'd0; A = '0; B = '0; CI = 1'b0;
      tick();
      tick();
      chk("rst_result", RESULT, 0);
      chk("rst_link", LINK, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      RESET_N = 1'b1;
      tick();
      chk("idle_busy", BUSY, 0);

      // ADD carry wrap, AND, PASS, ADD with carry-in
      run_op("add_wrap", 3'd0, 12'o7777, 12'o0001, 1'b0, 1, 12'o0000, 1'b1);
      run_op("add_ci",   3'd0, 12'o1234, 12'o0100, 1'b1, 1, 12'o1335, 1'b0);
      run_op("and",      3'd1, 12'o7070, 12'o1234, 1'b1, 1, 12'o1030, 1'b1);
      run_op("pass",     3'd7, 12'o5252, 12'o7777, 1'b0, 1, 12'o5252, 1'b0);

      // Single and double rotates through the link
      run_op("ral", 3'd2, 12'o4000, 12'o0000, 1'b0, 1, 12'o0000, 1'b1);
      run_op("rar", 3'd3, 12'o0000, 12'o0000, 1'b1, 1, 12'o4000, 1'b0);
      run_op("rtr", 3'd5, 12'o0001, 12'o0000, 1'b0, 2, 12'o4000, 1'b0);
      run_op("rtl", 3'd4, 12'o4000, 12'o0000, 1'b0, 2, 12'o0001, 1'b0);

`ifdef ADDAND_SEQ_BSW_EN
      bsw_exp = 12'o3412;
`else
      bsw_exp = 12'o1234;
`endif
      run_op("bsw_ci1", 3'd6, 12'o1234, 12'o7777, 1'b1, 1, bsw_exp, 1'b1);
      run_op("bsw_ci0", 3'd6, 12'o1234, 12'o0000, 1'b0, 1, bsw_exp, 1'b0);

      // Second START while RUN/FIN is ignored
      OP = 3'd0; A = 12'o0001; B = 12'o0002; CI = 1'b0; START = 1'b1;
      tick();
      chk("dbl_busy_k", BUSY, 1);
      A = 12'o7777; B = 12'o7777; CI = 1'b1;
      tick();
      chk("dbl_done", DONE, 1);
      chk("dbl_result", RESULT, 12'o0003);
      chk("dbl_link", LINK, 0);
      tick();
      START = 1'b0;
      chk("dbl_done_end", DONE, 0);
      chk("dbl_busy_end", BUSY, 0);
      tick();
      chk("dbl_no_accept", BUSY, 0);
      chk("dbl_no_done", DONE, 0);
      chk("dbl_result_hold", RESULT, 12'o0003);

      // Reset during RTL RUN abandons the operation
      run_op("pre_rst", 3'd7, 12'o6543, 12'o0000, 1'b1, 1, 12'o6543, 1'b1);
      OP = 3'd4; A = 12'o0707; CI = 1'b1; START = 1'b1;
      tick();
      START = 1'b0;
      chk("rrst_busy_k", BUSY, 1);
      RESET_N = 1'b0;
      tick();
      chk("rrst_busy", BUSY, 0);
      chk("rrst_done", DONE, 0);
      chk("rrst_result", RESULT, 12'o0000);
      chk("rrst_link", LINK, 0);
      RESET_N = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rrst_no_done", DONE, 0);
         chk("rrst_idle", BUSY, 0);
      end

      // START held through reset release is taken at the first live edge
      RESET_N = 1'b0; START = 1'b1; OP = 3'd0; A = 12'o0005; B = 12'o0006; CI = 1'b1;
      tick();
      chk("hold_rst_busy", BUSY, 0);
      RESET_N = 1'b1;
      tick();
      START = 1'b0;
      chk("hold_accept", BUSY, 1);
      tick();
      chk("hold_done", DONE, 1);
      chk("hold_result", RESULT, 12'o0014);
      chk("hold_link", LINK, 0);
      tick();
      chk("hold_end", BUSY, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
